// File: rtl/decoder_seq_onehot_if.sv
// Request/output bundle for decoder_seq_onehot.
// Handshake: a request transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready is combinational (idle and enabled).
// The master may hold in_valid; a request seen while in_ready is low is not
// consumed and has no effect.
interface decoder_seq_onehot_if #(
  parameter int AW     = 4,
  parameter int HOLD_W = 8
);
  logic              en_n;
  logic              in_valid;
  logic              in_ready;
  logic [AW-1:0]     in_addr;
  logic [HOLD_W-1:0] in_hold;
  logic              in_mode;
  logic [(1<<AW)-1:0] y;
  logic [AW-1:0]     cur_addr;
  logic              busy;
  logic              done;

  // Requester side: drives enable and the request, observes outputs.
  modport master (
    output en_n, in_valid, in_addr, in_hold, in_mode,
    input  in_ready, y, cur_addr, busy, done
  );

  // Decoder side.
  modport slave (
    input  en_n, in_valid, in_addr, in_hold, in_mode,
    output in_ready, y, cur_addr, busy, done
  );
endinterface

// File: rtl/decoder_seq_onehot.sv
// Registered N-to-2^N one-hot decoder with hold time and optional scan.
// Each accepted address is driven on y for in_hold+1 cycles. In scan mode
// the address then walks upward to 2^AW-1 with no gap, ending there.
// Optional feature macro: DECODER_SCAN_EN (undefined: in_mode is ignored
// and every request is a single-address request).
// dbg_state exposes the FSM state (0 = idle, 1 = drive).
module decoder_seq_onehot #(
  parameter int AW     = 4,
  parameter int HOLD_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  decoder_seq_onehot_if.slave bus,
  output logic [0:0]          dbg_state
);

  localparam int OW = 1 << AW;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};
  localparam logic [OW-1:0] Y_ONE     = {{(OW-1){1'b0}}, 1'b1};

  logic [0:0]        state_q, state_d;
  logic [OW-1:0]     y_q, y_d;
  logic [AW-1:0]     cur_addr_q, cur_addr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;

  logic in_ready_w;
  logic expire_w;
  logic advance_w;

`ifdef DECODER_SCAN_EN
  // Reload value and mode are only needed to continue a scan.
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              mode_q, mode_d;
`else
  logic unused_mode;
  assign unused_mode = bus.in_mode;
`endif

  assign in_ready_w = (state_q == ST_IDLE) && !bus.en_n;
  // The counter counts down to zero; the edge that sees zero ends the slot.
  assign expire_w   = (cnt_q == '0);

`ifdef DECODER_SCAN_EN
  // Continue only while there is a higher address left; checked before the
  // increment so cur_addr never wraps.
  assign advance_w = mode_q && (cur_addr_q != ADDR_LAST);
`else
  assign advance_w = 1'b0;
`endif

  // Next-state logic: enable abort has priority over everything else.
  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
`ifdef DECODER_SCAN_EN
    hold_d     = hold_q;
    mode_d     = mode_q;
`endif
    if (bus.en_n) begin
      state_d = ST_IDLE;
      y_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          y_d = '0;
          if (bus.in_valid) begin
            state_d    = ST_DRIVE;
            y_d        = Y_ONE << bus.in_addr;
            cur_addr_d = bus.in_addr;
            cnt_d      = bus.in_hold;
`ifdef DECODER_SCAN_EN
            hold_d     = bus.in_hold;
            mode_d     = bus.in_mode;
`endif
          end
        end
        ST_DRIVE: begin
          if (!expire_w) begin
            cnt_d = cnt_q - HOLD_W'(1);
          end else if (advance_w) begin
            cur_addr_d = cur_addr_q + AW'(1);
            y_d        = y_q << 1;
`ifdef DECODER_SCAN_EN
            cnt_d      = hold_q;
`endif
          end else begin
            state_d = ST_IDLE;
            y_d     = '0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          y_d     = '0;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      y_q        <= '0;
      cur_addr_q <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
`ifdef DECODER_SCAN_EN
      hold_q     <= '0;
      mode_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
`ifdef DECODER_SCAN_EN
      hold_q     <= hold_d;
      mode_q     <= mode_d;
`endif
    end
  end

  assign bus.in_ready = in_ready_w;
  assign bus.y        = y_q;
  assign bus.cur_addr = cur_addr_q;
  assign bus.busy     = (state_q == ST_DRIVE);
  assign bus.done     = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_decoder_seq_onehot.sv
// Self-checking bench for decoder_seq_onehot (AW=4, HOLD_W=8).
// A queue-based transaction model predicts the outputs every cycle; directed
// scenarios add literal expectations; a randomized phase follows.
module tb_decoder_seq_onehot;
  localparam int AW     = 4;
  localparam int HOLD_W = 8;
  localparam int OW     = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder_seq_onehot_if #(.AW(AW), .HOLD_W(HOLD_W)) bus ();
  logic [0:0] dbg_state;

  decoder_seq_onehot #(.AW(AW), .HOLD_W(HOLD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A request is expanded into the list of addresses it drives, one entry per
  // output cycle; the model pops one entry per clock edge.
  int  m_plan[$];
  bit  m_busy;
  bit  m_done;
  int  m_cur;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_plan.delete();
      m_busy = 0;
      m_done = 0;
      m_cur  = 0;
    end else begin
      m_done = 0;
      if (bus.en_n) begin
        m_plan.delete();
        m_busy = 0;
      end else if (!m_busy) begin
        if (bus.in_valid) begin
          int s, last, h;
          s    = int'(bus.in_addr);
          h    = int'(bus.in_hold);
          last = s;
`ifdef DECODER_SCAN_EN
          if (bus.in_mode) last = OW - 1;
`endif
          for (int a = s; a <= last; a++)
            for (int k = 0; k <= h; k++) m_plan.push_back(a);
          m_cur  = m_plan.pop_front();
          m_busy = 1;
        end
      end else begin
        if (m_plan.size() == 0) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_cur = m_plan.pop_front();
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      logic [OW-1:0] exp_y;
      exp_y = m_busy ? (OW'(1) << m_cur) : '0;
      check("y",        32'(bus.y),        32'(exp_y));
      check("cur_addr", 32'(bus.cur_addr), 32'(m_cur));
      check("busy",     32'(bus.busy),     32'(m_busy));
      check("done",     32'(bus.done),     32'(m_done));
      check("in_ready", 32'(bus.in_ready), 32'(!m_busy && !bus.en_n));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int addr, input int hold, input bit mode);
    bus.in_valid = 1'b1;
    bus.in_addr  = AW'(addr);
    bus.in_hold  = HOLD_W'(hold);
    bus.in_mode  = mode;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    rst          = 1'b1;
    bus.en_n     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_hold  = '0;
    bus.in_mode  = 1'b0;
    #1;
    check("rst_y",        32'(bus.y), 32'h0);
    check("rst_cur_addr", 32'(bus.cur_addr), 32'h0);
    check("rst_ready",    32'(bus.in_ready), 32'h1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();

    // single: addr 5, H=2
    request(5, 2, 1'b0);
    check("single_y0", 32'(bus.y), 32'h0020);
    step(); check("single_y1", 32'(bus.y), 32'h0020);
    step(); check("single_y2", 32'(bus.y), 32'h0020);
    check("single_cur", 32'(bus.cur_addr), 32'd5);
    step(); check("single_end_y", 32'(bus.y), 32'h0000);
    check("single_done", 32'(bus.done), 32'h1);
    step(); check("single_done_pulse", 32'(bus.done), 32'h0);

    // scan: addr 13, H=0
    request(13, 0, 1'b1);
    check("scan_y0", 32'(bus.y), 32'h2000);
`ifdef DECODER_SCAN_EN
    step(); check("scan_y1", 32'(bus.y), 32'h4000);
    step(); check("scan_y2", 32'(bus.y), 32'h8000);
    check("scan_cur", 32'(bus.cur_addr), 32'd15);
`endif
    step(); check("scan_end_y", 32'(bus.y), 32'h0000);
    check("scan_done", 32'(bus.done), 32'h1);
    step();

    // abort: addr 7, H=20, en_n high at cycle 4
    request(7, 20, 1'b0);
    repeat (3) step();
    bus.en_n     = 1'b1;
    bus.in_valid = 1'b1;
    #1 check("abort_ready_now", 32'(bus.in_ready), 32'h0);
    step(); check("abort_y", 32'(bus.y), 32'h0);
    check("abort_done", 32'(bus.done), 32'h0);
    check("abort_cur", 32'(bus.cur_addr), 32'd7);
    step(); check("abort_refuse", 32'(bus.busy), 32'h0);
    bus.in_valid = 1'b0;
    bus.en_n     = 1'b0;
    step();

    // back-to-back: held valid, addr 0 then 15, H=0
    bus.in_valid = 1'b1; bus.in_addr = 4'd0; bus.in_hold = '0; bus.in_mode = 1'b0;
    step(); check("b2b_y0", 32'(bus.y), 32'h0001);
    bus.in_addr = 4'd15;
    step(); check("b2b_y1", 32'(bus.y), 32'h0000);
    check("b2b_done1", 32'(bus.done), 32'h1);
    step(); check("b2b_y2", 32'(bus.y), 32'h8000);
    bus.in_valid = 1'b0;
    step(); check("b2b_y3", 32'(bus.y), 32'h0000);
    check("b2b_done2", 32'(bus.done), 32'h1);
    step();

    // max hold: addr 9, H=255
    request(9, 255, 1'b0);
    cnt = 0;
    while (bus.y == 16'h0200 && cnt < 300) begin
      cnt++;
      step();
    end
    check("maxhold_cycles", 32'(cnt), 32'd256);
    check("maxhold_done", 32'(bus.done), 32'h1);
    step();

    // reset mid-DRIVE: addr 3, H=10
    request(3, 10, 1'b0);
    step();
    #2 rst = 1'b1;
    #1;
    check("midrst_y",     32'(bus.y), 32'h0);
    check("midrst_busy",  32'(bus.busy), 32'h0);
    check("midrst_done",  32'(bus.done), 32'h0);
    check("midrst_ready", 32'(bus.in_ready), 32'h1);
    rst = 1'b0;
    request(3, 10, 1'b0);
    check("postrst_y", 32'(bus.y), 32'h0008);
    bus.en_n = 1'b1;
    step();
    bus.en_n = 1'b0;

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      bus.en_n     = ($urandom_range(0, 39) == 0);
      bus.in_valid = $urandom_range(0, 1);
      bus.in_addr  = AW'($urandom_range(0, OW - 1));
      bus.in_hold  = ($urandom_range(0, 9) == 0) ? HOLD_W'($urandom_range(0, 20))
                                                 : HOLD_W'($urandom_range(0, 3));
      bus.in_mode  = $urandom_range(0, 1);
      step();
    end

    bus.in_valid = 1'b0;
    bus.en_n     = 1'b1;
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
